// File: rtl/cva6_bht_local_hist.sv
// Branch history table with a per-entry local history register.
// Each entry holds a trained flag, a short shift register of recent outcomes
// for branches mapping to it, and one 2-bit saturating counter per history
// pattern. A sweep state machine initialises every entry after reset or flush.
module cva6_bht_local_hist #(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned HIST_BITS  = 3,
  parameter int unsigned VLEN       = 64,
  parameter bit          RVC        = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bht_i,
  output logic            ready_o,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            resp_valid_o,
  output logic            resp_hit_o,
  output logic            resp_taken_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i
);

  localparam int unsigned IDX  = $clog2(NR_ENTRIES);
  localparam int unsigned OFS  = RVC ? 1 : 2;
  localparam int unsigned NCNT = 1 << HIST_BITS;
  localparam int unsigned CW   = 2 * NCNT;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + 2'b01;
      else            r = c;
    end else begin
      if (c != 2'b00) r = c - 2'b01;
      else            r = c;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [IDX-1:0]        ptr_q, ptr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic                  resp_taken_q, resp_taken_d;

  // Table storage; written through a single port, never reset directly.
  logic                  tbl_valid_q [NR_ENTRIES];
  logic [HIST_BITS-1:0]  tbl_hist_q  [NR_ENTRIES];
  logic [CW-1:0]         tbl_cnt_q   [NR_ENTRIES];

  logic                  wr_en_s;
  logic [IDX-1:0]        wr_idx_s;
  logic                  wr_valid_s;
  logic [HIST_BITS-1:0]  wr_hist_s;
  logic [CW-1:0]         wr_cnt_s;

  logic [IDX-1:0]        lk_idx_s;
  logic                  lk_valid_s;
  logic [HIST_BITS-1:0]  lk_hist_s;
  logic [CW-1:0]         lk_cnt_s;
  logic [IDX-1:0]        up_idx_s;
  logic [HIST_BITS-1:0]  up_hist_s;
  logic [CW-1:0]         up_cnt_s;
  logic [1:0]            up_ctr_s;
  logic                  unused_pc_s;

  assign lk_idx_s    = lookup_pc_i[OFS +: IDX];
  assign up_idx_s    = upd_pc_i[OFS +: IDX];
  assign unused_pc_s = ^{lookup_pc_i, upd_pc_i};
  assign ready_o      = (state_q == ST_READY);
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_taken_o = resp_taken_q;

  // Sweep sequencing: walk every entry once, then open for traffic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (flush_bht_i) begin
          ptr_d = {IDX{1'b0}};
        end else if (ptr_q == IDX'(NR_ENTRIES - 1)) begin
          state_d = ST_READY;
          ptr_d   = {IDX{1'b0}};
        end else begin
          ptr_d = ptr_q + IDX'(1);
        end
      end
      ST_READY: begin
        if (flush_bht_i) begin
          state_d = ST_INIT;
          ptr_d   = {IDX{1'b0}};
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = {IDX{1'b0}};
      end
    endcase
  end

  // Lookup read path; responses come from the state before this edge's write.
  always_comb begin
    lk_valid_s   = tbl_valid_q[lk_idx_s];
    lk_hist_s    = tbl_hist_q[lk_idx_s];
    lk_cnt_s     = tbl_cnt_q[lk_idx_s];
    resp_valid_d = lookup_valid_i && (state_q == ST_READY);
    resp_hit_d   = resp_valid_d & lk_valid_s;
    resp_taken_d = resp_valid_d & lk_valid_s & lk_cnt_s[{lk_hist_s, 1'b1}];
  end

  // Write port arbitration: the sweep owns the port in INIT, updates in READY.
  always_comb begin
    up_hist_s  = tbl_hist_q[up_idx_s];
    up_cnt_s   = tbl_cnt_q[up_idx_s];
    up_ctr_s   = up_cnt_s[{up_hist_s, 1'b0} +: 2];
    wr_en_s    = 1'b0;
    wr_idx_s   = ptr_q;
    wr_valid_s = 1'b0;
    wr_hist_s  = {HIST_BITS{1'b0}};
    wr_cnt_s   = {NCNT{2'b01}};
    if (rst_i) begin
      wr_en_s = 1'b0;
    end else if (state_q == ST_INIT) begin
      wr_en_s = 1'b1;
    end else if (upd_valid_i && !flush_bht_i) begin
      wr_en_s    = 1'b1;
      wr_idx_s   = up_idx_s;
      wr_valid_s = 1'b1;
      wr_hist_s  = HIST_BITS'({up_hist_s, upd_taken_i});
      wr_cnt_s   = up_cnt_s;
      wr_cnt_s[{up_hist_s, 1'b0} +: 2] = sat_next(up_ctr_s, upd_taken_i);
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      ptr_q        <= {IDX{1'b0}};
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_taken_q <= resp_taken_d;
    end
  end

  // Table write: one entry per cycle, RAM-style.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      tbl_valid_q[wr_idx_s] <= wr_valid_s;
      tbl_hist_q[wr_idx_s]  <= wr_hist_s;
      tbl_cnt_q[wr_idx_s]   <= wr_cnt_s;
    end
  end

endmodule

// File: tb/tb_cva6_bht_local_hist.sv
// Scoreboard bench for cva6_bht_local_hist: a behavioural table model predicts
// each lookup response and the ready flag; a monitor compares on the falling edge.
module tb_cva6_bht_local_hist;

  localparam int NR = 128;
  localparam int NH = 8;
  localparam logic [63:0] PC8  = 64'h0000_0000_8000_0010;
  localparam logic [63:0] PC16 = 64'h0000_0000_8000_0020;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_bht_i = 1'b0;
  logic        ready_o;
  logic        lookup_valid_i = 1'b0;
  logic [63:0] lookup_pc_i = 64'd0;
  logic        resp_valid_o, resp_hit_o, resp_taken_o;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = 64'd0;
  logic        upd_taken_i = 1'b0;

  always #5 clk = ~clk;

  cva6_bht_local_hist #(.NR_ENTRIES(128), .HIST_BITS(3), .VLEN(64), .RVC(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_bht_i(flush_bht_i), .ready_o(ready_o),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_taken_o(resp_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers per entry, indexed by the PC halfword number.
  int   m_left = NR;
  bit   chk_en = 1'b0;
  bit   m_valid [NR];
  int   m_hist  [NR];
  int   m_cnt   [NR][NH];
  logic [1:0] exp_q [$];
  logic [1:0] mon_e;

  function automatic int pc_idx(input logic [63:0] pc);
    return int'((pc >> 1) % 64'd128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wipe();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_hist[i]  = 0;
      for (int j = 0; j < NH; j++) m_cnt[i][j] = 1;
    end
  endtask

  // Model step at each rising edge, using inputs as the DUT sees them.
  always @(posedge clk) begin : model
    int i, h;
    if (rst_i) begin
      m_left = NR;
      chk_en = 1'b1;
      wipe();
    end else begin
      if (m_left == 0 && lookup_valid_i) begin
        i = pc_idx(lookup_pc_i);
        exp_q.push_back({m_valid[i], m_valid[i] && (m_cnt[i][m_hist[i]] >= 2)});
      end
      if (m_left == 0 && upd_valid_i && !flush_bht_i) begin
        i = pc_idx(upd_pc_i);
        h = m_hist[i];
        if (upd_taken_i) m_cnt[i][h] = (m_cnt[i][h] >= 3) ? 3 : m_cnt[i][h] + 1;
        else             m_cnt[i][h] = (m_cnt[i][h] <= 0) ? 0 : m_cnt[i][h] - 1;
        m_hist[i]  = (h * 2 + (upd_taken_i ? 1 : 0)) % NH;
        m_valid[i] = 1'b1;
      end
      if (flush_bht_i) begin
        m_left = NR;
        wipe();
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
    end
  end

  // Monitor: compare ready and any presented response against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready_o), 32'(m_left == 0));
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_unexpected: got resp_valid_o=1 expected 0 at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_hit", 32'(resp_hit_o), 32'(mon_e[1]));
          chk("resp_taken", 32'(resp_taken_o), 32'(mon_e[0]));
        end
      end else begin
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL resp_missing: got resp_valid_o=0 expected 1 at %0t", $time);
        end
        chk("idle_out", 32'({resp_hit_o, resp_taken_o}), 32'(2'b00));
      end
    end
  end

  task automatic step(input logic lv, input logic [63:0] lpc, input logic uv,
                      input logic [63:0] upc, input logic ut, input logic fl, input logic rs);
    lookup_valid_i = lv; lookup_pc_i = lpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    flush_bht_i = fl; rst_i = rs;
    @(posedge clk);
    #1;
    lookup_valid_i = 1'b0; upd_valid_i = 1'b0; flush_bht_i = 1'b0; rst_i = 1'b0;
  endtask

  // Count cycles until ready, issuing lookups that must all be ignored.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 1000) begin
      lookup_valid_i = 1'b1;
      lookup_pc_i = PC8;
      @(posedge clk);
      #1;
      n++;
    end
    lookup_valid_i = 1'b0;
  endtask

  task automatic direct(input string name, input logic hit, input logic taken);
    @(negedge clk);
    #1;
    chk({name, "_valid"}, 32'(resp_valid_o), 32'(1'b1));
    chk({name, "_hit"}, 32'(resp_hit_o), 32'(hit));
    chk({name, "_taken"}, 32'(resp_taken_o), 32'(taken));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [63:0] pa, pb;
    wipe();
    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    wait_ready(n);
    chk("init_len", 32'(n), 32'd128);

    step(1'b1, PC8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    direct("cold", 1'b0, 1'b0);

    step(1'b0, 64'd0, 1'b1, PC8, 1'b1, 1'b0, 1'b0);
    step(1'b1, PC8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    direct("train1", 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 64'd0, 1'b1, PC8, 1'b1, 1'b0, 1'b0);
      step(1'b1, PC8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    end
    direct("train8", 1'b1, 1'b1);

    for (int k = 0; k < 3; k++) step(1'b0, 64'd0, 1'b1, PC16, 1'b0, 1'b0, 1'b0);
    step(1'b1, PC16, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    direct("sat_low", 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b1, PC16, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NH; k++) begin
      step(1'b1, PC16, 1'b1, PC16, 1'(k % 2 == 0), 1'b0, 1'b0);
    end

    step(1'b1, PC8, 1'b1, PC8, 1'b0, 1'b0, 1'b0);
    direct("same_cycle_pre", 1'b1, 1'b1);
    step(1'b1, PC8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    direct("same_cycle_post", 1'b1, 1'b0);

    step(1'b0, 64'd0, 1'b1, PC8, 1'b1, 1'b1, 1'b0);
    wait_ready(n);
    chk("flush_len", 32'(n), 32'd128);
    step(1'b1, PC8, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    direct("post_flush", 1'b0, 1'b0);

    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 49; k++) step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    wait_ready(n);
    chk("rst_mid_sweep_len", 32'(n), 32'd128);

    for (int k = 0; k < 3000; k++) begin
      pa = {$urandom, $urandom};
      pb = {$urandom, $urandom};
      pa[7:1] = 7'($urandom_range(0, 7));
      pb[7:1] = 7'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), pa, 1'($urandom_range(0, 1)), pb,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 999) == 0));
    end

    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
